// File: rtl/uart_tx_queue_pkg.sv
// Shared defaults and FSM state encoding for the UART transmit queue.
package uart_tx_queue_pkg;

    localparam int DEPTH_DEF  = 16;
    localparam int AW_DEF     = 4;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAITB = 2'd1,
        S_WAITD = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Core-side write port plus transmitter issue handshake of the UART transmit queue.
interface uart_tx_queue_if #(parameter int AW = 4);

    logic          wr_en;
    logic          wr_word;
    logic [31:0]   wr_data;
    logic          wr_ready;
    logic          flush;
    logic          ovf;
    logic          ovf_clr;
    logic [AW:0]   count;
    logic          empty;
    logic [7:0]    sdata;
    logic          tx_start;
    logic          tx_busy;

    modport master (
        output wr_en, wr_word, wr_data, flush, ovf_clr, tx_busy,
        input  wr_ready, ovf, count, empty, sdata, tx_start
    );

    modport slave (
        input  wr_en, wr_word, wr_data, flush, ovf_clr, tx_busy,
        output wr_ready, ovf, count, empty, sdata, tx_start
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// Purpose: byte FIFO with 1-or-4-byte push, 1-byte pop, flush, count/free outputs.
// Latency: pushed bytes visible at head the cycle after the push edge.
// Backpressure: none internally; caller must only push when free covers the push size.
module uart_byte_fifo
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_byte,
    input  logic          push_word,
    input  logic [31:0]   push_dat,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    head_dat,
    output logic [AW:0]   count,
    output logic [AW:0]   free
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   n_push;

    always_comb begin
        n_push = '0;
        if (push_word)
            n_push = (AW+1)'(WORD_BYTES);
        else if (push_byte)
            n_push = (AW+1)'(1);
    end

    assign head_dat = mem[rp];
    assign free     = (AW+1)'(DEPTH) - count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            rp    <= wp;
            count <= '0;
        end else begin
            // Low AW bits of n_push give the modulo-DEPTH pointer step.
            wp    <= wp + n_push[AW-1:0];
            rp    <= rp + AW'(pop);
            count <= count + n_push - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && !flush) begin
            if (push_word) begin
                for (int i = 0; i < WORD_BYTES; i++)
                    mem[wp + AW'(i)] <= push_dat[8*i +: 8];
            end else if (push_byte) begin
                mem[wp] <= push_dat[7:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Purpose: byte queue feeding the UART sender; byte/word writes in, one byte per issue out.
// Latency: byte written into an empty idle queue at edge N issues tx_start after edge N+1.
// Backpressure: wr_ready drops when the write does not fit; dropped writes set sticky ovf.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    uart_tx_queue_if.slave  q
);

    logic [AW:0]  count;
    logic [AW:0]  free;
    logic [7:0]   head_dat;
    logic         empty;
    logic         wr_ok;
    logic         issue;
    logic         ovf_r;
    logic [7:0]   sdata_r;
    logic [7:0]   sdata_nxt;
    logic         tx_start_r;
    logic         tx_start_nxt;
    tx_state_e    state;
    tx_state_e    state_nxt;

    assign q.wr_ready = q.wr_word ? (free >= (AW+1)'(WORD_BYTES)) : (free != '0);
    // Flush wins over a same-cycle write; the write is silently discarded.
    assign wr_ok      = q.wr_en & q.wr_ready & ~q.flush;
    assign empty      = (count == '0);

    uart_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push_byte (wr_ok & ~q.wr_word),
        .push_word (wr_ok &  q.wr_word),
        .push_dat  (q.wr_data),
        .pop       (issue),
        .flush     (q.flush),
        .head_dat  (head_dat),
        .count     (count),
        .free      (free)
    );

    always_ff @(posedge clk) begin
        if (!rstn)
            ovf_r <= 1'b0;
        else if (q.wr_en && !q.wr_ready)
            ovf_r <= 1'b1;
        else if (q.ovf_clr)
            ovf_r <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            sdata_r    <= 8'h00;
            tx_start_r <= 1'b0;
        end else begin
            state      <= state_nxt;
            sdata_r    <= sdata_nxt;
            tx_start_r <= tx_start_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sdata_nxt    = sdata_r;
        tx_start_nxt = 1'b0;
        issue        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !q.tx_busy && !q.flush) begin
                    issue        = 1'b1;
                    sdata_nxt    = head_dat;
                    tx_start_nxt = 1'b1;
                    state_nxt    = S_WAITB;
                end
            end
            S_WAITB: if (q.tx_busy)  state_nxt = S_WAITD;
            S_WAITD: if (!q.tx_busy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign q.count    = count;
    assign q.empty    = empty;
    assign q.ovf      = ovf_r;
    assign q.sdata    = sdata_r;
    assign q.tx_start = tx_start_r;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: transmitter stand-in plus queue-based scoreboard of issued bytes.
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int FRAME = 80;
    localparam int DRAIN = DEPTH * (FRAME + 6) + 50;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uart_tx_queue_if #(.AW(AW)) bus();

    uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .q    (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];
    logic       ovf_m = 1'b0;

    // Transmitter stand-in: busy from the edge after tx_start for one frame.
    int         busy_cnt = 0;
    logic       tx_hold  = 1'b0;
    int         viol     = 0;
    int         sd_viol  = 0;
    logic [7:0] last_sd  = 8'h00;
    logic       last_rst = 1'b0;

    assign bus.tx_busy = tx_hold | (busy_cnt != 0);

    always @(posedge clk) begin
        if (!rstn) begin
            busy_cnt <= 0;
        end else if (bus.tx_start) begin
            if (bus.tx_busy) viol <= viol + 1;
            busy_cnt <= FRAME;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (last_rst && bus.sdata != last_sd && !bus.tx_start) sd_viol <= sd_viol + 1;
        last_sd  <= bus.sdata;
        last_rst <= rstn;
    end

    task automatic drive_idle();
        bus.wr_en   = 1'b0;
        bus.wr_word = 1'b0;
        bus.wr_data = 32'h0;
        bus.flush   = 1'b0;
        bus.ovf_clr = 1'b0;
    endtask

    // One clock; any issued byte is popped from the scoreboard and its value compared.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (bus.tx_start) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected sdata=%h want no issue", bus.sdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.sdata !== e) begin
                    bad++;
                    $display("FAIL issue_order sdata=%h want=%h", bus.sdata, e);
                end
            end
        end
    endtask

    task automatic cycle(input logic en, input logic word, input logic [31:0] d,
                         input logic fl, input logic clr,
                         output logic rdy_exp, output logic rdy_dut);
        bus.wr_en   = en;
        bus.wr_word = word;
        bus.wr_data = d;
        bus.flush   = fl;
        bus.ovf_clr = clr;
        #1;
        rdy_dut = bus.wr_ready;
        rdy_exp = (DEPTH - exp_q.size()) >= (word ? 4 : 1);
        tick();
        if (fl) exp_q.delete();
        else if (en && rdy_exp) begin
            if (word) for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
            else exp_q.push_back(d[7:0]);
        end
        if (en && !rdy_exp) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        drive_idle();
    endtask

    task automatic wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < DRAIN && !done; i++) begin
            if (exp_q.size() == 0 && !bus.tx_busy && !bus.tx_start) done = 1'b1;
            else tick();
        end
        tick();
        total++;
        if (!done || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain left=%0d want=0 within %0d cycles", name, exp_q.size(), DRAIN);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        tx_hold = 1'b0;
        rstn = 1'b0;
        repeat (3) tick();
        exp_q.delete();
        ovf_m = 1'b0;
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
        total++; if (bus.sdata !== 8'h00) begin bad++; $display("FAIL reset_sdata got=%h want=00", bus.sdata); end
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b want=0", bus.tx_start); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", bus.wr_ready); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic re, rd;
        cycle(1'b1, 1'b0, 32'h0000_00A5, 1'b0, 1'b0, re, rd);
        total++; if (rd !== re) begin bad++; $display("FAIL single_ready got=%b want=%b", rd, re); end
        total++; if (bus.count !== 5'd1 || bus.tx_start !== 1'b0)
            begin bad++; $display("FAIL single_after_write count=%0d tx_start=%b want 1,0", bus.count, bus.tx_start); end
        tick();
        total++; if (bus.tx_start !== 1'b1 || bus.sdata !== 8'hA5)
            begin bad++; $display("FAIL single_latency tx_start=%b sdata=%h want 1,a5", bus.tx_start, bus.sdata); end
        total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1)
            begin bad++; $display("FAIL single_count count=%0d empty=%b want 0,1", bus.count, bus.empty); end
        tick();
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL single_pulse tx_start=%b want 0", bus.tx_start); end
        wait_drain("single");
        total++; if (bus.sdata !== 8'hA5) begin bad++; $display("FAIL single_sdata_hold got=%h want=a5", bus.sdata); end
    endtask

    task automatic test_word();
        logic re, rd;
        int   want;
        cycle(1'b1, 1'b1, 32'h4433_2211, 1'b0, 1'b0, re, rd);
        total++; if (rd !== re) begin bad++; $display("FAIL word_ready got=%b want=%b", rd, re); end
        total++; if (bus.count !== 5'd4) begin bad++; $display("FAIL word_count got=%0d want=4", bus.count); end
        want = 3;
        for (int i = 0; i < DRAIN && exp_q.size() != 0; i++) begin
            tick();
            if (bus.tx_start) begin
                total++;
                if (bus.count !== 5'(want)) begin bad++; $display("FAIL word_count_step got=%0d want=%0d", bus.count, want); end
                want--;
            end
        end
        total++; if (want != -1) begin bad++; $display("FAIL word_issues remaining=%0d want=-1", want); end
        wait_drain("word");
    endtask

    task automatic test_overflow();
        logic re, rd;
        tx_hold = 1'b1;
        for (int i = 0; i < 13; i++) cycle(1'b1, 1'b0, $urandom, 1'b0, 1'b0, re, rd);
        total++; if (bus.count !== 5'd13) begin bad++; $display("FAIL ovf_fill got=%0d want=13", bus.count); end
        cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b0, re, rd);
        total++; if (rd !== re) begin bad++; $display("FAIL ovf_word_ready got=%b want=%b", rd, re); end
        total++; if (bus.count !== 5'(exp_q.size()) || bus.ovf !== ovf_m)
            begin bad++; $display("FAIL ovf_word_drop count=%0d ovf=%b want %0d,%b", bus.count, bus.ovf, exp_q.size(), ovf_m); end
        cycle(1'b1, 1'b0, $urandom, 1'b0, 1'b0, re, rd);
        total++; if (rd !== re || bus.count !== 5'd14)
            begin bad++; $display("FAIL ovf_byte_ok ready=%b count=%0d want %b,14", rd, bus.count, re); end
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, re, rd);
        total++; if (bus.ovf !== ovf_m) begin bad++; $display("FAIL ovf_clear got=%b want=%b", bus.ovf, ovf_m); end
        cycle(1'b1, 1'b0, $urandom, 1'b0, 1'b0, re, rd);
        cycle(1'b1, 1'b0, $urandom, 1'b0, 1'b0, re, rd);
        cycle(1'b1, 1'b0, $urandom, 1'b0, 1'b1, re, rd);
        total++; if (rd !== re || bus.count !== 5'd16 || bus.ovf !== ovf_m)
            begin bad++; $display("FAIL ovf_full_set_prio ready=%b count=%0d ovf=%b want %b,16,%b", rd, bus.count, bus.ovf, re, ovf_m); end
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, re, rd);
        tx_hold = 1'b0;
        wait_drain("ovf");
    endtask

    task automatic test_wrap();
        logic re, rd;
        for (int pass = 0; pass < 2; pass++) begin
            tx_hold = 1'b1;
            for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 32'(pass * 16 + i), 1'b0, 1'b0, re, rd);
            total++; if (bus.count !== 5'd16 || bus.wr_ready !== 1'b0)
                begin bad++; $display("FAIL wrap_full pass=%0d count=%0d ready=%b want 16,0", pass, bus.count, bus.wr_ready); end
            tx_hold = 1'b0;
            wait_drain("wrap");
        end
    endtask

    task automatic test_flush();
        logic re, rd;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, $urandom, 1'b0, 1'b0, re, rd);
        for (int i = 0; i < 20 && !bus.tx_busy; i++) tick();
        total++; if (bus.tx_busy !== 1'b1) begin bad++; $display("FAIL flush_busy got=%b want=1", bus.tx_busy); end
        cycle(1'b1, 1'b1, $urandom, 1'b1, 1'b0, re, rd);
        total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1)
            begin bad++; $display("FAIL flush_clear count=%0d empty=%b want 0,1", bus.count, bus.empty); end
        repeat (FRAME + 20) tick();
        total++; if (bus.tx_busy !== 1'b0 || bus.count !== 5'd0)
            begin bad++; $display("FAIL flush_complete busy=%b count=%0d want 0,0", bus.tx_busy, bus.count); end
    endtask

    task automatic test_reset_mid();
        logic re, rd;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, $urandom, 1'b0, 1'b0, re, rd);
        for (int i = 0; i < 20 && !bus.tx_busy; i++) tick();
        repeat (28) tick();
        exp_q.delete();
        ovf_m = 1'b0;
        rstn = 1'b0;
        repeat (2) tick();
        total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.ovf !== 1'b0)
            begin bad++; $display("FAIL rstmid_state count=%0d empty=%b ovf=%b want 0,1,0", bus.count, bus.empty, bus.ovf); end
        total++; if (bus.sdata !== 8'h00 || bus.tx_start !== 1'b0 || bus.tx_busy !== 1'b0)
            begin bad++; $display("FAIL rstmid_out sdata=%h start=%b busy=%b want 00,0,0", bus.sdata, bus.tx_start, bus.tx_busy); end
        rstn = 1'b1;
        tick();
        cycle(1'b1, 1'b0, 32'h0000_003C, 1'b0, 1'b0, re, rd);
        wait_drain("rstmid");
        total++; if (bus.sdata !== 8'h3C) begin bad++; $display("FAIL rstmid_byte got=%h want=3c", bus.sdata); end
    endtask

    task automatic test_random();
        logic re, rd;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0), re, rd);
            total++;
            if (rd !== re || bus.count !== 5'(exp_q.size()) || bus.ovf !== ovf_m ||
                bus.empty !== (exp_q.size() == 0)) begin
                bad++;
                $display("FAIL rand_step%0d ready=%b count=%0d ovf=%b empty=%b want %b,%0d,%b,%b",
                         i, rd, bus.count, bus.ovf, bus.empty, re, exp_q.size(), ovf_m, exp_q.size() == 0);
            end
        end
        wait_drain("rand");
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_single();
        test_word();
        test_overflow();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        total++; if (viol != 0) begin bad++; $display("FAIL issue_while_busy got=%0d want=0", viol); end
        total++; if (sd_viol != 0) begin bad++; $display("FAIL sdata_stable got=%0d want=0", sd_viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
